// File: rtl/instr_fetch_unit.sv
// Instruction sequencer: owns the PC, fetches over imem req/rvalid, presents decode fields.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            PC_STEP    = 4,
    parameter logic [5:0]             HALT_OP    = 6'h3F,
    parameter int unsigned            TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [31:0]           imem_rdata,
    output logic [5:0]            op_code,
    output logic [5:0]            func_code,
    output logic [15:0]           imm16,
    output logic                  instr_valid,
    input  logic                  PC_WE,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  mem_done,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [15:0]           instr_count,
    output logic                  halted,
    output logic                  fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           ir_q, ir_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  advance;
    logic [ADDR_WIDTH-1:0] next_pc;

    // Branch targets are forced word-aligned; the low bits are deliberately dropped.
    logic unused_target_bits;
    assign unused_target_bits = ^branch_target[1:0];

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic          err_q, err_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;
`endif

    assign advance = PC_WE || mem_done;
    assign next_pc = branch_taken ? {branch_target[ADDR_WIDTH-1:2], 2'b00}
                                  : pc_q + ADDR_WIDTH'(PC_STEP);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            cnt_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
            err_q   <= 1'b0;
            wcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
`ifdef FETCH_TIMEOUT_EN
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
`ifdef FETCH_TIMEOUT_EN
        err_d   = err_q;
        wcnt_d  = wcnt_q;
`endif
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                wcnt_d  = '0;
`endif
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    ir_d    = imem_rdata;
                    state_d = (imem_rdata[31:26] == HALT_OP) ? S_HALT : S_EXEC;
                end
`ifdef FETCH_TIMEOUT_EN
                // Retry the same pc once TIMEOUT wait cycles pass with no response.
                else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_REQ;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
                end
`endif
            end
            S_EXEC: begin
                if (advance) begin
                    pc_d    = next_pc;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_REQ;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_EXEC);
    assign op_code     = instr_valid ? ir_q[31:26] : '0;
    assign func_code   = instr_valid ? ir_q[5:0]   : '0;
    assign imm16       = instr_valid ? ir_q[15:0]  : '0;
    assign pc          = pc_q;
    assign instr_count = cnt_q;
    assign halted      = (state_q == S_HALT);
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err   = err_q;
`else
    assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected fetches and retirements are queued,
// a monitor compares them as the DUT presents imem_req and instr_valid.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        PC_WE, branch_taken, mem_done;
    logic [31:0] branch_target;

    logic        imem_req, instr_valid, halted, fetch_err;
    logic [31:0] imem_addr, pc;
    logic [5:0]  op_code, func_code;
    logic [15:0] imm16, instr_count;

    logic        w_req, w_valid, w_halted, w_err;
    logic [31:0] w_addr, w_pc;
    logic [5:0]  w_op, w_func;
    logic [15:0] w_imm, w_cnt;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .op_code(op_code),
        .func_code(func_code), .imm16(imm16), .instr_valid(instr_valid), .PC_WE(PC_WE),
        .branch_taken(branch_taken), .branch_target(branch_target), .mem_done(mem_done),
        .pc(pc), .instr_count(instr_count), .halted(halted), .fetch_err(fetch_err)
    );

    // Runs in lockstep with u_dut on the same responses; used for the wrap check.
    instr_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset_n(reset_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .op_code(w_op),
        .func_code(w_func), .imm16(w_imm), .instr_valid(w_valid), .PC_WE(PC_WE),
        .branch_taken(branch_taken), .branch_target(branch_target), .mem_done(mem_done),
        .pc(w_pc), .instr_count(w_cnt), .halted(w_halted), .fetch_err(w_err)
    );

    typedef struct { logic [31:0] addr; int gap; } req_t;
    typedef struct { logic [31:0] pc; int len; logic [15:0] cnt; } ret_t;
    typedef struct { bit we; int stall; bit sbr; bit br; logic [31:0] tgt;
                     logic [31:0] pc; int gap; } ent_t;

    req_t req_q[$];
    ret_t ret_q[$];
    int   checks = 0;
    int   errors = 0;

    int          rsp_lat  = 1;
    logic [31:0] dead_addr = 32'hDEAD_0000;
    logic [31:0] halt_addr = 32'h0000_0104;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory responder: answers each request rsp_lat cycles later.
    initial begin
        int          pend = 0;
        logic [31:0] a_l  = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = (a_l == halt_addr) ? 32'hFC00_0000 : 32'h0000_0020;
                end
            end
            if (imem_req === 1'b1 && imem_addr !== dead_addr) begin
                pend = rsp_lat;
                a_l  = imem_addr;
            end
        end
    end

    // Monitor
    initial begin
        int          cyc = 0, last_req = 0, nreq = 0, len = 0;
        bit          in_exec = 0;
        logic [31:0] spc = '0;
        req_t        r;
        ret_t        e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n === 1'b1) begin
                if (imem_req === 1'b1) begin
                    if (req_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_req: addr %h, none expected", imem_addr);
                    end else begin
                        r = req_q.pop_front();
                        chk("req_addr", imem_addr, r.addr);
                        if (r.gap != 0) chk("req_gap", 32'(cyc - last_req), 32'(r.gap));
                        if (nreq < 2) begin
                            chk("wrap_req", {31'd0, w_req}, 32'd1);
                            chk("wrap_addr", w_addr, (nreq == 0) ? 32'hFFFF_FFFC : 32'h0);
                        end
                        nreq++;
                    end
                    last_req = cyc;
                end
                if (instr_valid === 1'b1) begin
                    if (!in_exec) begin
                        in_exec = 1; len = 1; spc = pc;
                        chk("op_code", {26'd0, op_code}, 32'h0);
                        chk("func_code", {26'd0, func_code}, 32'h20);
                        chk("imm16", {16'd0, imm16}, 32'h0020);
                    end else begin
                        len++;
                        chk("exec_pc_hold", pc, spc);
                    end
                end else begin
                    chk("idle_fields", {4'd0, op_code, func_code, imm16}, 32'h0);
                    if (in_exec) begin
                        in_exec = 0;
                        if (ret_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_retire: pc %h", spc);
                        end else begin
                            e = ret_q.pop_front();
                            chk("retire_pc", spc, e.pc);
                            chk("retire_len", 32'(len), 32'(e.len));
                            chk("retire_count", {16'd0, instr_count}, {16'd0, e.cnt});
                        end
                    end
                end
            end
        end
    end

    task automatic run_entry(input ent_t t);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL exec_timeout: no instr_valid for pc %h, got 0 expected 1", t.pc);
            return;
        end
        if (t.we) begin
            PC_WE = 1'b1; branch_taken = t.br; branch_target = t.tgt;
            @(negedge clk);
        end else begin
            PC_WE = 1'b0; mem_done = 1'b0; branch_taken = t.sbr; branch_target = 32'h200;
            repeat (t.stall) @(negedge clk);
            mem_done = 1'b1; branch_taken = t.br; branch_target = t.tgt;
            @(negedge clk);
        end
        PC_WE = 1'b1; mem_done = 1'b0; branch_taken = 1'b0; branch_target = '0;
    endtask

    ent_t prog[6];

    initial begin
        bit ok;
        prog[0] = '{1, 0, 0, 0, 32'h0,   32'h000, 0};
        prog[1] = '{1, 0, 0, 0, 32'h0,   32'h004, 3};
        prog[2] = '{1, 0, 0, 0, 32'h0,   32'h008, 3};
        prog[3] = '{0, 5, 1, 0, 32'h0,   32'h00C, 3};
        prog[4] = '{1, 0, 0, 1, 32'h103, 32'h010, 8};
        prog[5] = '{1, 0, 0, 0, 32'h0,   32'h100, 3};

        reset_n = 1'b0; PC_WE = 1'b1; branch_taken = 1'b0; branch_target = '0; mem_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("rst_count", {16'd0, instr_count}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            req_q.push_back('{prog[i].pc, prog[i].gap});
            ret_q.push_back('{prog[i].pc, prog[i].stall + 1, 16'(i + 1)});
        end
        req_q.push_back('{32'h104, 3});
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) run_entry(prog[i]);

        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (halted === 1'b1) begin ok = 1; break; end
        end
        chk("halt_reached", {31'd0, ok}, 32'd1);
        chk("halt_pc", pc, 32'h104);
        chk("halt_count", {16'd0, instr_count}, 32'd6);
        repeat (20) @(negedge clk);
        chk("halt_hold", {31'd0, halted}, 32'd1);
        chk("halt_count_hold", {16'd0, instr_count}, 32'd6);

        // Reset during WAIT with a late response that must be discarded.
        dead_addr = 32'h4;
        reset_n = 1'b0; rsp_lat = 2;
        repeat (2) @(negedge clk);
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_count", {16'd0, instr_count}, 32'd0);
        req_q.push_back('{32'h0, 0});
        reset_n = 1'b1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1) begin ok = 1; break; end
        end
        chk("rst2_req_seen", {31'd0, ok}, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        req_q.push_back('{32'h0, 0});
        ret_q.push_back('{32'h0, 1, 16'd1});
        req_q.push_back('{32'h4, 3});
        @(negedge clk);
        reset_n = 1'b1; rsp_lat = 1;
        run_entry('{1, 0, 0, 0, 32'h0, 32'h0, 0});

`ifdef FETCH_TIMEOUT_EN
        req_q.push_back('{32'h4, 17});
        for (int i = 0; i < 60 && req_q.size() != 0; i++) @(negedge clk);
        chk("timeout_err", {31'd0, fetch_err}, 32'd1);
`else
        repeat (30) @(negedge clk);
        chk("no_timeout_err", {31'd0, fetch_err}, 32'd0);
`endif
        chk("pc_timeout", pc, 32'h4);
        chk("req_queue_empty", 32'(req_q.size()), 32'd0);
        chk("ret_queue_empty", 32'(ret_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
